// File: rtl/param_delay_line.sv
// Multi-lane delay line with a run-time selectable delay of 1..DELAY_MAX advancing cycles.
// Samples carry a valid bit; en stalls, flush and delay_load clear the pipeline synchronously.
module param_delay_line #(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 2,
    parameter int DELAY_MAX  = 8,
    parameter int DELAY_INIT = 1,
    parameter int DW         = $clog2(DELAY_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      clear_n,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      delay_load,
    input  logic [DW-1:0]             delay_val,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [DW-1:0]             cur_delay,
    output logic                      filled
);

    localparam int DATA_W   = CHANNELS * WIDTH;
    localparam int NST      = (DELAY_MAX > 1) ? (DELAY_MAX - 1) : 1;
    localparam int INIT_INT = (DELAY_INIT < 1) ? 1 :
                              ((DELAY_INIT > DELAY_MAX) ? DELAY_MAX : DELAY_INIT);
    localparam logic [DW-1:0] INIT_D = DW'(INIT_INT);
    localparam logic [DW-1:0] MAX_D  = DW'(DELAY_MAX);
    localparam logic [DW-1:0] ONE_D  = DW'(32'd1);

    function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] v);
        if (v == '0) begin
            return ONE_D;
        end else if (v > MAX_D) begin
            return MAX_D;
        end else begin
            return v;
        end
    endfunction

    logic [DATA_W-1:0] stage_data_q  [NST];
    logic              stage_valid_q [NST];

    logic [DW-1:0]     cur_delay_q, cur_delay_d;
    logic [DW-1:0]     fill_cnt_q, fill_cnt_d;
    logic              filled_q, filled_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              clr_s;
    logic              adv_s;
    logic [DATA_W-1:0] tap_data_s;
    logic              tap_valid_s;
    logic [DW-1:0]     cnt_inc_s;
    logic              filled_adv_s;

    // Tap select: delay 1 feeds the output register straight from the input,
    // delay D reads stage D-2.
    always_comb begin
        tap_data_s  = in_data;
        tap_valid_s = in_valid;
        for (int k = 0; k < NST; k++) begin
            tap_data_s  = (cur_delay_q == DW'(k + 2)) ? stage_data_q[k]  : tap_data_s;
            tap_valid_s = (cur_delay_q == DW'(k + 2)) ? stage_valid_q[k] : tap_valid_s;
        end
    end

    // Next-state for delay, fill tracking and the output register (load > flush > en).
    always_comb begin
        clr_s        = delay_load | flush;
        adv_s        = en & ~clr_s;
        cnt_inc_s    = (fill_cnt_q == MAX_D) ? fill_cnt_q : (fill_cnt_q + ONE_D);
        filled_adv_s = (cnt_inc_s >= cur_delay_q);
        cur_delay_d  = delay_load ? clamp_delay(delay_val) : cur_delay_q;
        fill_cnt_d   = fill_cnt_q;
        filled_d     = filled_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        if (clr_s) begin
            fill_cnt_d  = '0;
            filled_d    = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else if (en) begin
            fill_cnt_d  = cnt_inc_s;
            filled_d    = filled_adv_s;
            out_valid_d = tap_valid_s & filled_adv_s;
            out_data_d  = tap_data_s;
        end else begin
            fill_cnt_d  = fill_cnt_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cur_delay_q <= INIT_D;
            fill_cnt_q  <= '0;
            filled_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cur_delay_q <= cur_delay_d;
            fill_cnt_q  <= fill_cnt_d;
            filled_q    <= filled_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Shift chain: every stage moves on an advancing edge regardless of the tap in use.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int k = 0; k < NST; k++) begin
                stage_data_q[k]  <= '0;
                stage_valid_q[k] <= 1'b0;
            end
        end else if (clr_s) begin
            for (int k = 0; k < NST; k++) begin
                stage_data_q[k]  <= '0;
                stage_valid_q[k] <= 1'b0;
            end
        end else if (adv_s) begin
            stage_data_q[0]  <= in_data;
            stage_valid_q[0] <= in_valid;
            for (int k = 1; k < NST; k++) begin
                stage_data_q[k]  <= stage_data_q[k-1];
                stage_valid_q[k] <= stage_valid_q[k-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cur_delay = cur_delay_q;
    assign filled    = filled_q;

endmodule

// File: tb/tb_param_delay_line.sv
// Directed plus random bench for param_delay_line; expected outputs come from a
// history-queue model: output after an advancing edge is the input D advancing edges back.
module tb_param_delay_line;

    localparam int DW    = 4;
    localparam int DMAX  = 8;
    localparam int DAT_W = 64;

    logic             clk;
    logic             clear_n;
    logic             en;
    logic             flush;
    logic             delay_load;
    logic [DW-1:0]    delay_val;
    logic             in_valid;
    logic [DAT_W-1:0] in_data;
    logic             out_valid;
    logic [DAT_W-1:0] out_data;
    logic [DW-1:0]    cur_delay;
    logic             filled;

    param_delay_line #(
        .WIDTH(32), .CHANNELS(2), .DELAY_MAX(DMAX), .DELAY_INIT(1)
    ) dut (
        .clk(clk), .clear_n(clear_n), .en(en), .flush(flush),
        .delay_load(delay_load), .delay_val(delay_val),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .cur_delay(cur_delay), .filled(filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [DAT_W-1:0] d;
    } smp_t;

    smp_t hist[$];
    int   m_delay;
    int   n_vec;
    int   n_err;

    task automatic chk(input string tag, input logic [DAT_W-1:0] obs, input logic [DAT_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_m(input int v);
        if (v == 0) return 1;
        if (v > DMAX) return DMAX;
        return v;
    endfunction

    task automatic check_model(input string tag);
        smp_t e;
        logic f;
        e.v = 1'b0;
        e.d = '0;
        f   = 1'b0;
        if (hist.size() >= m_delay) begin
            e = hist[hist.size() - m_delay];
            f = 1'b1;
        end
        chk({tag, ".data"},   out_data, e.d);
        chk({tag, ".valid"},  {63'd0, out_valid}, {63'd0, e.v});
        chk({tag, ".filled"}, {63'd0, filled}, {63'd0, f});
        chk({tag, ".delay"},  {60'd0, cur_delay}, 64'(m_delay));
    endtask

    task automatic step(input string tag, input logic e, input logic f, input logic l,
                        input logic [DW-1:0] dv, input logic v, input logic [DAT_W-1:0] d);
        smp_t s;
        en = e; flush = f; delay_load = l; delay_val = dv; in_valid = v; in_data = d;
        @(posedge clk);
        if (l) begin
            m_delay = clamp_m(int'(dv));
            hist.delete();
        end else if (f) begin
            hist.delete();
        end else if (e) begin
            s.v = v;
            s.d = d;
            hist.push_back(s);
            if (hist.size() > 20) void'(hist.pop_front());
        end
        #1;
        check_model(tag);
    endtask

    task automatic stream(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 64'(base + i));
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_delay = 1;
        clear_n = 1'b0; en = 1'b0; flush = 1'b0; delay_load = 1'b0;
        delay_val = 4'd0; in_valid = 1'b0; in_data = 64'd0;
        #12;
        check_model("reset");
        clear_n = 1'b1;
        #10;

        // D=1 after reset: sample appears on the next edge
        step("d1", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 64'h00000022_00000011);
        chk("d1.const", out_data, 64'h00000022_00000011);

        // D=5 streaming: first output on the 5th advancing edge
        step("ld5", 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 64'd0);
        stream("s5a", 1, 4);
        chk("s5.notyet", {63'd0, out_valid}, 64'd0);
        stream("s5b", 5, 1);
        chk("s5.first", out_data, 64'd1);
        chk("s5.filled", {63'd0, filled}, 64'd1);
        stream("s5c", 6, 4);

        // D=4 with a 3-cycle stall mid-stream
        step("ld4", 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 64'd0);
        stream("s4a", 10, 5);
        for (int i = 0; i < 3; i++)
            step("stall", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 64'hdead);
        chk("stall.hold", out_data, 64'd11);
        stream("s4b", 15, 6);

        // D=3 flush mid-stream
        step("ld3", 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 64'd0);
        stream("s3a", 40, 5);
        step("flush", 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 64'hbad);
        chk("flush.data", out_data, 64'd0);
        stream("s3b", 60, 3);
        chk("flush.first", out_data, 64'd60);

        // Clamp and load+flush together
        step("ld0", 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 64'd7);
        chk("clamp0", {60'd0, cur_delay}, 64'd1);
        step("ld15", 1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 64'd7);
        chk("clamp15", {60'd0, cur_delay}, 64'd8);
        stream("s8", 70, 9);
        step("ldfl", 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 64'd9);
        chk("ldfl.delay", {60'd0, cur_delay}, 64'd2);

        // Async reset mid-stream at D=6
        step("ld6", 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 64'd0);
        stream("s6", 80, 8);
        #2;
        clear_n = 1'b0;
        #1;
        m_delay = 1;
        hist.delete();
        check_model("areset");
        #3;
        clear_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r_en, r_fl, r_ld, r_v;
            logic [DW-1:0] r_dv;
            r_en = ($urandom_range(0, 4) != 0);
            r_fl = ($urandom_range(0, 30) == 0);
            r_ld = ($urandom_range(0, 30) == 0);
            r_v  = $urandom_range(0, 1) == 1;
            r_dv = DW'($urandom_range(0, 15));
            step("rand", r_en, r_fl, r_ld, r_dv, r_v, {$urandom(), $urandom()});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_delay_line.md
Name: param_delay_line

Overview:
- Multi-channel, runtime-programmable delay line for aligning datapath streams, e.g. matching twiddle/control paths to butterfly pipeline latency in the FFT.
- Successor to the fixed-delay register chain:
  - delay selectable at run time (1..DELAY_MAX)
  - CHANNELS parallel lanes
  - per-sample valid tracking, advance-enable (stall), synchronous flush
- Sits between pipeline stages wherever latency must be matched without re-synthesis.

Parameters:
- WIDTH, 32, bits per channel sample.
- CHANNELS, 2, number of parallel lanes sharing one delay setting.
- DELAY_MAX, 8, maximum delay in advancing cycles; must be >= 1.
- DELAY_INIT, 1, delay applied after reset; clamped into 1..DELAY_MAX.
- DW, $clog2(DELAY_MAX+1), width of the delay value port.

Ports:
- clk  input  1  system clock, all state on rising edge.
- clear_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; 0 holds all state (stall).
- flush  input  1  synchronous flush of pipeline contents.
- delay_load  input  1  strobe; latch delay_val as new delay.
- delay_val  input  DW  requested delay in advancing cycles.
- in_valid  input  1  in_data holds a valid sample.
- in_data  input  CHANNELS*WIDTH  packed lanes, lane c at bits [c*WIDTH +: WIDTH].
- out_valid  output  1  out_data holds a valid delayed sample.
- out_data  output  CHANNELS*WIDTH  delayed packed lanes.
- cur_delay  output  DW  delay currently in effect.
- filled  output  1  pipeline has advanced >= cur_delay times since last reset/flush/load.

Behaviour:
- Reset (clear_n=0, async):
  - out_data=0, out_valid=0, filled=0.
  - All internal stage data and valid bits = 0.
  - cur_delay = clamp(DELAY_INIT).
- Latency:
  - With D=cur_delay, a sample presented on an edge with en=1 appears on out_data/out_valid (registered) after exactly D advancing edges.
  - D=1: out_data <= in_data on the same edge.
  - Edges with en=0 do not count toward latency.
- Lanes: all lanes delayed identically. valid travels alongside data. Invalid samples still shift; their data is passed through unmodified, not zeroed.
- Stall: en=0 holds every stage, out_data, out_valid and fill count; delay_load and flush still act (see priority).
- Flush (flush=1, synchronous, regardless of en):
  - all stage valid bits, out_valid, filled and fill count -> 0.
  - data registers -> 0.
  - cur_delay unchanged.
- Delay load (delay_load=1):
  - cur_delay <= clamp(delay_val), where 0 -> 1 and >DELAY_MAX -> DELAY_MAX.
  - Implies flush on the same edge, so no sample is ever emitted with a mixed/partial delay.
- Priority on one edge: clear_n > delay_load > flush > en advance. A flush/load edge discards the in_data sample on that edge.
- Fill counter:
  - saturating, counts advancing edges since last reset/flush/load, width DW.
  - filled=1 when count >= cur_delay; stays 1 until next flush/load/reset.
  - out_valid can be 1 only when filled=1.
- Storage:
  - DELAY_MAX-1 internal stages + output register per lane.
  - Tap selected by cur_delay; unused stages still shift.
- No combinational path from any input to any output.

Test Plan:
- Reset, D=DELAY_INIT=1, en=1, in_valid=1, in_data lane0=0x11, lane1=0x22 -> next edge out_data={0x22,0x11}, out_valid=1, filled=1.
- delay_load with delay_val=5, then stream lane0=1,2,3,... with en=1 -> out_valid first 1 on the 5th advancing edge after the first sample, out lane0=1, then 2,3... every cycle; filled rises on that same edge.
- D=4, stream values 10..20 with en=0 for 3 cycles mid-stream -> outputs freeze during the stall, sequence contiguous, each sample latency = 4 advancing edges.
- D=3 mid-stream, flush=1 -> out_valid=0, out_data=0, filled=0 next edge; first new sample emerges exactly 3 advancing edges after post-flush input.
- delay_val=0 -> cur_delay=1; delay_val=15 with DELAY_MAX=8 -> cur_delay=8; delay_load and flush together -> load applies, pipeline cleared.
- Assert clear_n=0 asynchronously mid-stream at D=6 -> outputs 0 immediately without a clock edge; cur_delay returns to DELAY_INIT.
